// File: rtl/cosine_lut_arbiter.sv
// cosine_lut_arbiter
//   Shares a single read port of an internal cosine lookup table between
//   N_REQ requesters (TX carrier, RX I mixer, RX Q mixer) using round-robin
//   arbitration. Each request may ask for cos(index) or sin(index); sine is
//   served from the same table via a quarter-period index offset.
//   One lookup per cycle, response registered one cycle after the handshake.
//
//   Table contents: entry i = round(cos(2*pi*i/P) * 2^(DATA_W-2)), i.e. signed
//   fixed point with DATA_W-2 fractional bits (unit amplitude fits exactly).
//
// Ports (cosine_lut_arbiter)
//   clk        in   1              clock, all logic on posedge
//   rst        in   1              synchronous active-high reset
//   req_valid  in   N_REQ          request pending per requester
//   req_ready  out  N_REQ          one-hot (or zero) grant, forced 0 during rst
//   req_addr   in   N_REQ*ADDR_W   phase index, requester i at [i*ADDR_W +: ADDR_W]
//   req_sin    in   N_REQ          1 = sin(index), 0 = cos(index)
//   rsp_valid  out  1              one strobe per accepted request
//   rsp_id     out  ID_W           requester the response belongs to
//   rsp_data   out  DATA_W         table sample, 0 for out-of-range index
//   rsp_err    out  1              accepted index was >= P

// Cosine table with READ_PORTS registered read ports (1-cycle latency).
// Ports: clk, rst (sync, clears read registers), rd_en, rd_addr, rd_data.
module cosine_lut #(
  parameter int P          = 48,
  parameter int ADDR_W     = $clog2(P),
  parameter int DATA_W     = 32,
  parameter int READ_PORTS = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [READ_PORTS-1:0]          rd_en,
  input  logic [READ_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [READ_PORTS*DATA_W-1:0]   rd_data
);

  function automatic logic [DATA_W-1:0] cos_sample(input int unsigned i);
    real    ang;
    real    scaled;
    longint v;
    ang    = 6.283185307179586 * real'(i) / real'(P);
    scaled = $cos(ang) * (2.0 ** (DATA_W - 2));
    v      = longint'(scaled);
    return DATA_W'(v);
  endfunction

  logic [DATA_W-1:0] rom [P];

  for (genvar gi = 0; gi < P; gi++) begin : g_rom
    assign rom[gi] = cos_sample(gi);
  end

  for (genvar gp = 0; gp < READ_PORTS; gp++) begin : g_port
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
      end else if (rd_en[gp]) begin
        data_q <= rom[rd_addr[gp*ADDR_W +: ADDR_W]];
      end
    end

    assign rd_data[gp*DATA_W +: DATA_W] = data_q;
  end

endmodule

module cosine_lut_arbiter #(
  parameter int N_REQ  = 3,
  parameter int P      = 48,
  parameter int ADDR_W = $clog2(P),
  parameter int DATA_W = 32,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0]          req_sin,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err
);

  localparam logic [ADDR_W:0] P_EXT      = (ADDR_W+1)'(P);
  localparam logic [ADDR_W:0] SIN_OFFSET = (ADDR_W+1)'(3 * P / 4);

  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              found;
  logic              hs;

  logic [ADDR_W-1:0] sel_addr;
  logic              sel_sin;
  logic [ADDR_W:0]   sin_sum;
  logic [ADDR_W-1:0] idx;
  logic              bad;
  logic              lut_en;
  logic [DATA_W-1:0] lut_data;

  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_err_q, rsp_err_d;
  logic              zero_q, zero_d;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned cand;
      cand = (32'(last_grant_q) + 1 + k) % N_REQ;
      if (!found && req_valid[ID_W'(cand)]) begin
        found            = 1'b1;
        gnt_id           = ID_W'(cand);
        gnt[ID_W'(cand)] = 1'b1;
      end
    end
  end

  assign req_ready = rst ? '0 : gnt;
  assign hs        = found & ~rst;

  // Sine via quarter-period shift: sin(x) = cos(x - P/4) = cos(x + 3P/4 mod P).
  always_comb begin
    sel_addr = req_addr[gnt_id*ADDR_W +: ADDR_W];
    sel_sin  = req_sin[gnt_id];
    sin_sum  = {1'b0, sel_addr} + SIN_OFFSET;
    if (sin_sum >= P_EXT) begin
      sin_sum = sin_sum - P_EXT;
    end
    idx = sel_sin ? sin_sum[ADDR_W-1:0] : sel_addr;
    bad = ({1'b0, sel_addr} >= P_EXT);
  end

  // Out-of-range indices never reach the table; the response is zeroed instead.
  assign lut_en = hs & ~bad;

  cosine_lut #(
    .P          (P),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .READ_PORTS (1)
  ) u_lut (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (lut_en),
    .rd_addr (idx),
    .rd_data (lut_data)
  );

  always_comb begin
    last_grant_d = last_grant_q;
    rsp_id_d     = rsp_id_q;
    zero_d       = zero_q;
    rsp_valid_d  = hs;
    rsp_err_d    = hs & bad;
    if (hs) begin
      last_grant_d = gnt_id;
      rsp_id_d     = gnt_id;
      zero_d       = bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= ID_W'(N_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      zero_q       <= zero_d;
    end
  end

  // The table read register holds on idle cycles, and zero_q only changes on
  // a handshake, so rsp_data keeps its last value while rsp_valid is low.
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = zero_q ? '0 : lut_data;

endmodule

// File: tb/tb_cosine_lut_arbiter.sv
// Testbench for cosine_lut_arbiter: directed scenarios followed by random
// traffic, checked against a behavioural model of the arbiter and table.
module tb_cosine_lut_arbiter;

  localparam int N  = 3;
  localparam int P  = 48;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_sin;
  logic            rsp_valid;
  logic [IW-1:0]   rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;

  always #5 clk = ~clk;

  cosine_lut_arbiter #(
    .N_REQ  (N),
    .P      (P),
    .ADDR_W (AW),
    .DATA_W (DW),
    .ID_W   (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_sin   (req_sin),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  int tests = 0;
  int fails = 0;

  // Model state
  int            ptr = N - 1;
  int            last_g;
  logic          e_rv;
  logic [IW-1:0] e_id;
  logic [DW-1:0] e_data;
  logic          e_err;

  function automatic logic [DW-1:0] ref_cos(input int i);
    real    ang;
    longint v;
    ang = 2.0 * 3.14159265358979323846 * real'(i) / real'(P);
    v   = longint'($cos(ang) * (2.0 ** (DW - 2)));
    return DW'(v);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input bit v, input int addr, input bit s);
    req_valid[i]            = v;
    req_addr[i*AW +: AW]    = AW'(addr);
    req_sin[i]              = s;
  endtask

  task automatic clear_all();
    req_valid = '0;
    req_addr  = '0;
    req_sin   = '0;
  endtask

  // One clock: check the grant mid-cycle, then the response after the edge.
  task automatic cycle();
    int           g;
    int           a;
    int           idx;
    logic [N-1:0] er;
    @(negedge clk);
    er = '0;
    g  = -1;
    if (!rst) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    last_g = g;
    if (rst) begin
      ptr = N - 1; e_rv = 1'b0; e_id = '0; e_data = '0; e_err = 1'b0;
    end else if (g >= 0) begin
      a    = int'(req_addr[g*AW +: AW]);
      e_rv = 1'b1;
      e_id = IW'(g);
      ptr  = g;
      if (a >= P) begin
        e_err  = 1'b1;
        e_data = '0;
      end else begin
        e_err  = 1'b0;
        idx    = req_sin[g] ? (a + 3 * P / 4) % P : a;
        e_data = ref_cos(idx);
      end
    end else begin
      e_rv  = 1'b0;
      e_err = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("rsp_err", 64'(rsp_err), 64'(e_err));
    chk("rsp_id", 64'(rsp_id), 64'(e_id));
    chk("rsp_data", 64'(rsp_data), 64'(e_data));
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    cycle();
    cycle();
    rst = 1'b0;

    // Single request from requester 0
    set_req(0, 1, 0, 0);
    cycle();
    chk("t1_data", 64'(rsp_data), 64'(ref_cos(0)));
    clear_all();
    cycle();

    // All requesters valid right after reset: strict rotation 0,1,2,...
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_req(0, 1, 5, 0);
    set_req(1, 1, 10, 1);
    set_req(2, 1, 20, 0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("rr_order", 64'(last_g), 64'(k % 3));
    end
    clear_all();
    cycle();

    // Sine wrap cases
    set_req(1, 1, P / 4, 1);
    cycle();
    chk("sin_wrap", 64'(rsp_data), 64'(ref_cos(0)));
    set_req(1, 1, 0, 1);
    cycle();
    chk("sin_zero", 64'(rsp_data), 64'(ref_cos(3 * P / 4)));
    clear_all();
    cycle();

    // Out-of-range index
    set_req(2, 1, P, 0);
    cycle();
    chk("err_flag", 64'(rsp_err), 64'(1));
    clear_all();
    cycle();
    chk("err_hold_data", 64'(rsp_data), 64'(0));

    // Reset during a grant cycle
    set_req(0, 1, 3, 0);
    cycle();
    set_req(0, 1, 7, 0);
    set_req(2, 1, 9, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("post_rst_grant", 64'(last_g), 64'(0));
    clear_all();
    cycle();

    // Full sweep from requester 0
    for (int a = 0; a < P; a++) begin
      set_req(0, 1, a, 0);
      cycle();
    end
    clear_all();
    cycle();

    // Random traffic; pending requests keep their payload until granted
    for (int n = 0; n < 400; n++) begin
      bit was_rst;
      rst = ($urandom_range(0, 39) == 0);
      was_rst = rst;
      cycle();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_g == i || was_rst) begin
          set_req(i, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 63)),
                  bit'($urandom_range(0, 1)));
        end
      end
    end
    rst = 1'b0;
    clear_all();
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
